// File: rtl/icon_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_dtypes / icon_tx_arbiter
//  Description : Channel types for the interconnect transmit/receive paths,
//                and a round-robin arbiter that shares one interconnect
//                transmit channel between NUM_REQ requesters. The winner's
//                payload and opx bit are registered onto the shared channel
//                and held until the interconnect returns success. That
//                success is then routed back to the granted requester.
//  Ports       :
//    i_clk        in   clock, all state updates on rising edge
//    i_reset      in   synchronous active-high reset
//    i_req_tx     in   per-requester addr/data/valid
//    i_req_opx    in   per-requester destination operand select
//    o_req_rx     out  per-requester success return (combinational)
//    o_icon_tx    out  shared channel payload (registered)
//    o_icon_opx   out  shared channel opx (registered)
//    i_icon_rx    in   success from the interconnect
//    o_grant_idx  out  index of current holder (registered)
//    o_busy       out  high while a transfer is held
//  Revision    : 1.0 - initial release
// ============================================================================

package pkg_dtypes;

  typedef struct packed {
    logic [3:0] euidx;
    logic [3:0] regidx;
  } type_icon_addr;

  typedef struct packed {
    type_icon_addr addr;
    logic [31:0]   data;
    logic          valid;
  } type_icon_tx_channel;

  typedef struct packed {
    logic success;
  } type_icon_rx_channel;

endpackage

module icon_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOG2_NUM_REQ = $clog2(NUM_REQ)
) (
  input  logic                                           i_clk,
  input  logic                                           i_reset,
  input  pkg_dtypes::type_icon_tx_channel [NUM_REQ-1:0]  i_req_tx,
  input  logic [NUM_REQ-1:0]                             i_req_opx,
  output pkg_dtypes::type_icon_rx_channel [NUM_REQ-1:0]  o_req_rx,
  output pkg_dtypes::type_icon_tx_channel                o_icon_tx,
  output logic                                           o_icon_opx,
  input  pkg_dtypes::type_icon_rx_channel                i_icon_rx,
  output logic [LOG2_NUM_REQ-1:0]                        o_grant_idx,
  output logic                                           o_busy
);

  localparam logic [LOG2_NUM_REQ:0]   c_num_req = (LOG2_NUM_REQ+1)'(NUM_REQ);
  localparam logic [LOG2_NUM_REQ-1:0] c_last    = LOG2_NUM_REQ'(NUM_REQ-1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } t_state;

  t_state                          r_state;
  t_state                          w_nxt_state;
  logic [LOG2_NUM_REQ-1:0]         r_rr_ptr;
  logic [LOG2_NUM_REQ-1:0]         w_nxt_rr;
  pkg_dtypes::type_icon_tx_channel r_tx;
  pkg_dtypes::type_icon_tx_channel w_nxt_tx;
  logic                            r_opx;
  logic                            w_nxt_opx;
  logic [LOG2_NUM_REQ-1:0]         r_grant_idx;
  logic [LOG2_NUM_REQ-1:0]         w_nxt_grant;

  logic [NUM_REQ-1:0]              w_req_valid;
  logic [NUM_REQ-1:0]              w_excl;
  logic [LOG2_NUM_REQ-1:0]         w_grant_next;
  logic [LOG2_NUM_REQ:0]           w_sel_idle;
  logic [LOG2_NUM_REQ:0]           w_sel_next;
  logic                            w_success;
  logic                            w_pick_en;
  logic [LOG2_NUM_REQ-1:0]         w_pick_idx;

  // Returns {found, index} of the first set bit of i_valid, scanning from
  // i_start upward with wrap at NUM_REQ (not at a power of two).
  function automatic logic [LOG2_NUM_REQ:0] f_select(
    input logic [NUM_REQ-1:0]      i_valid,
    input logic [LOG2_NUM_REQ-1:0] i_start
  );
    logic                    found;
    logic [LOG2_NUM_REQ-1:0] sel;
    logic [LOG2_NUM_REQ:0]   idx;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, i_start} + (LOG2_NUM_REQ+1)'(i);
      if (idx >= c_num_req) begin
        idx = idx - c_num_req;
      end
      if (!found && i_valid[idx[LOG2_NUM_REQ-1:0]]) begin
        found = 1'b1;
        sel   = idx[LOG2_NUM_REQ-1:0];
      end
    end
    return {found, sel};
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_req_valid[gi]      = i_req_tx[gi].valid;
      assign w_excl[gi]           = (r_grant_idx == LOG2_NUM_REQ'(gi));
      assign o_req_rx[gi].success = w_success && (r_grant_idx == LOG2_NUM_REQ'(gi));
    end
  endgenerate

  // Success only counts while a transfer is held, and never in a reset cycle.
  assign w_success    = (r_state == ST_HOLD) && i_icon_rx.success && !i_reset;
  assign w_grant_next = (r_grant_idx == c_last) ? '0 : r_grant_idx + 1'b1;

  // Fresh search from the pointer (IDLE) and the back-to-back search that
  // starts just past the holder and skips it (HOLD with success).
  assign w_sel_idle = f_select(w_req_valid, r_rr_ptr);
  assign w_sel_next = f_select(w_req_valid & ~w_excl, w_grant_next);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_rr    = r_rr_ptr;
    w_nxt_tx    = r_tx;
    w_nxt_opx   = r_opx;
    w_nxt_grant = r_grant_idx;
    w_pick_en   = 1'b0;
    w_pick_idx  = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_sel_idle[LOG2_NUM_REQ]) begin
          w_pick_en  = 1'b1;
          w_pick_idx = w_sel_idle[LOG2_NUM_REQ-1:0];
        end
      end
      ST_HOLD: begin
        if (w_success) begin
          w_nxt_rr = w_grant_next;
          if (w_sel_next[LOG2_NUM_REQ]) begin
            w_pick_en  = 1'b1;
            w_pick_idx = w_sel_next[LOG2_NUM_REQ-1:0];
          end else begin
            w_nxt_tx.valid = 1'b0;
            w_nxt_state    = ST_IDLE;
          end
        end else if (!w_req_valid[r_grant_idx]) begin
          // Holder withdrew before completion: drop the transfer silently.
          w_nxt_rr       = w_grant_next;
          w_nxt_tx.valid = 1'b0;
          w_nxt_state    = ST_IDLE;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase

    if (w_pick_en) begin
      w_nxt_tx       = i_req_tx[w_pick_idx];
      w_nxt_tx.valid = 1'b1;
      w_nxt_opx      = i_req_opx[w_pick_idx];
      w_nxt_grant    = w_pick_idx;
      w_nxt_state    = ST_HOLD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_tx        <= '0;
      r_opx       <= 1'b0;
      r_grant_idx <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_rr_ptr    <= w_nxt_rr;
      r_tx        <= w_nxt_tx;
      r_opx       <= w_nxt_opx;
      r_grant_idx <= w_nxt_grant;
    end
  end

  assign o_icon_tx   = r_tx;
  assign o_icon_opx  = r_opx;
  assign o_grant_idx = r_grant_idx;
  assign o_busy      = (r_state == ST_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_icon_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icon_tx_arbiter
//  Description : Self-checking bench for icon_tx_arbiter. Directed scenarios
//                followed by randomized traffic, all compared each cycle
//                against a behavioural reference model of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icon_tx_arbiter;
  import pkg_dtypes::*;

  localparam int N = 4;

  logic                           clk = 1'b0;
  logic                           rst;
  type_icon_tx_channel [N-1:0]    req_tx;
  logic [N-1:0]                   req_opx;
  type_icon_rx_channel [N-1:0]    req_rx;
  type_icon_tx_channel            icon_tx;
  logic                           icon_opx;
  type_icon_rx_channel            icon_rx;
  logic [1:0]                     grant_idx;
  logic                           busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit                  m_busy;
  int                  m_g;
  int                  m_ptr;
  type_icon_tx_channel m_tx;
  logic                m_opx;

  always #5 clk = ~clk;

  icon_tx_arbiter #(.NUM_REQ(N)) u_dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_tx    (req_tx),
    .i_req_opx   (req_opx),
    .o_req_rx    (req_rx),
    .o_icon_tx   (icon_tx),
    .o_icon_opx  (icon_opx),
    .i_icon_rx   (icon_rx),
    .o_grant_idx (grant_idx),
    .o_busy      (busy)
  );

  task automatic t_check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // First valid requester at or after start (mod N), skipping excl.
  function automatic int f_search(input int start, input int excl);
    for (int off = 0; off < N; off++) begin
      int k;
      k = (start + off) % N;
      if (req_tx[k].valid && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_busy = 1'b0;
    m_g    = 0;
    m_ptr  = 0;
    m_tx   = '0;
    m_opx  = 1'b0;
  endtask

  task automatic m_grant(input int k);
    m_busy = 1'b1;
    m_g    = k;
    m_tx   = req_tx[k];
    m_opx  = req_opx[k];
  endtask

  // One clock: compare outputs at negedge, advance model, step past posedge.
  task automatic cycle();
    logic [N-1:0] exp_rx;
    logic [N-1:0] act_rx;
    int k;
    @(negedge clk);
    exp_rx = '0;
    if (!rst && m_busy && icon_rx.success) exp_rx[m_g] = 1'b1;
    for (int i = 0; i < N; i++) act_rx[i] = req_rx[i].success;
    t_check("req_rx",   64'(act_rx),         64'(exp_rx));
    t_check("valid",    64'(icon_tx.valid),  64'(m_busy));
    t_check("busy",     64'(busy),           64'(m_busy));
    t_check("tx",       64'(icon_tx),        64'(m_tx));
    t_check("opx",      64'(icon_opx),       64'(m_opx));
    t_check("grant",    64'(grant_idx),      64'(m_g));

    if (rst) begin
      m_reset();
    end else if (!m_busy) begin
      k = f_search(m_ptr, -1);
      if (k >= 0) m_grant(k);
    end else if (icon_rx.success) begin
      m_ptr = (m_g + 1) % N;
      k = f_search(m_ptr, m_g);
      if (k >= 0) m_grant(k);
      else begin
        m_busy   = 1'b0;
        m_tx.valid = 1'b0;
      end
    end else if (!req_tx[m_g].valid) begin
      m_busy     = 1'b0;
      m_tx.valid = 1'b0;
      m_ptr      = (m_g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst     = 1'b0;
    req_tx  = '0;
    req_opx = '0;
    icon_rx = '0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int fair_seq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    m_reset();
    quiet();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    t_check("reset_tx",    64'(icon_tx),   64'd0);
    t_check("reset_grant", 64'(grant_idx), 64'd0);

    // Single request
    cycle();
    req_tx[2].addr.euidx = 4'd1;
    req_tx[2].data       = 32'hA5;
    req_tx[2].valid      = 1'b1;
    req_opx[2]           = 1'b1;
    cycle();
    t_check("single_data",  64'(icon_tx.data), 64'hA5);
    t_check("single_opx",   64'(icon_opx),     64'd1);
    t_check("single_grant", 64'(grant_idx),    64'd2);
    req_tx[2].data = 32'h5A;   // ignored while held
    cycle();
    t_check("single_hold",  64'(icon_tx.data), 64'hA5);
    icon_rx.success = 1'b1;
    cycle();
    icon_rx.success = 1'b0;
    req_tx[2].valid = 1'b0;
    t_check("single_done",  64'(icon_tx.valid), 64'd0);
    cycle();

    // Fairness: all valid, success every cycle
    do_reset();
    for (int i = 0; i < N; i++) req_tx[i].valid = 1'b1;
    icon_rx.success = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      t_check("fair_grant", 64'(grant_idx),     64'(fair_seq[i]));
      t_check("fair_valid", 64'(icon_tx.valid), 64'd1);
    end

    // Pointer priority: complete a transfer for 1, then 1 and 3 compete
    do_reset();
    req_tx[1].valid = 1'b1;
    cycle();
    icon_rx.success = 1'b1;
    cycle();
    icon_rx.success = 1'b0;
    req_tx[3].valid = 1'b1;
    cycle();
    t_check("prio_first", 64'(grant_idx), 64'd3);
    icon_rx.success = 1'b1;
    cycle();
    t_check("prio_second", 64'(grant_idx), 64'd1);
    icon_rx.success = 1'b0;
    cycle();

    // Abort: requester 0 withdraws, next search starts at 1
    do_reset();
    req_tx[0].valid = 1'b1;
    cycle();
    cycle();
    req_tx[0].valid = 1'b0;
    cycle();
    t_check("abort_valid", 64'(icon_tx.valid), 64'd0);
    req_tx[0].valid = 1'b1;
    req_tx[2].valid = 1'b1;
    cycle();
    t_check("abort_next", 64'(grant_idx), 64'd2);

    // Reset mid-HOLD with success present, then stray success in IDLE
    icon_rx.success = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    icon_rx.success = 1'b0;
    t_check("rst_hold_valid", 64'(icon_tx.valid), 64'd0);
    req_tx = '0;
    req_tx[1].valid = 1'b1;
    req_tx[3].valid = 1'b1;
    cycle();
    t_check("rst_next_grant", 64'(grant_idx), 64'd1);
    req_tx = '0;
    cycle();
    icon_rx.success = 1'b1;
    cycle();
    icon_rx.success = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req_tx[k].valid) begin
          if ($urandom % 8 == 0) req_tx[k].valid = 1'b0;
        end else if ($urandom % 3 == 0) begin
          req_tx[k].valid = 1'b1;
        end
        req_tx[k].data = $urandom;
        req_tx[k].addr = 8'($urandom);
        req_opx[k]     = 1'($urandom);
      end
      icon_rx.success = ($urandom % 3 == 0);
      rst             = ($urandom % 100 == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
